// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard/forwarding controller.
//   track_entry_t : one in-flight writeback tracked after ID
//                   {valid, wb_en, mem_read, dest}; dest is sized for the
//                   widest supported register index and zero-extended.
//   FWD_RF        : forwarding select meaning "read the register file".
//   sel_width()   : width of a select that encodes 0..stages.
package hazard_pkg;

  localparam int MAX_REG_W = 8;
  localparam int FWD_RF    = 0;

  typedef struct packed {
    logic                 valid;
    logic                 wb_en;
    logic                 mem_read;
    logic [MAX_REG_W-1:0] dest;
  } track_entry_t;

  function automatic int sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Per-source dependency check against the writeback tracker.
//   tracker   in  : STAGES entries, index 0 = youngest (EXE)
//   src       in  : source register index
//   src_en    in  : source is a real operand
//   match     out : per-stage match vector
//   any_match out : at least one stage matches
//   youngest  out : lowest matching stage index (0 when no match)
//   load_use  out : youngest match is a load still in stage 0
module hazard_src_check
  import hazard_pkg::*;
#(
  parameter int REG_W  = 4,
  parameter int STAGES = 3,
  parameter int IDX_W  = 2
) (
  input  track_entry_t [STAGES-1:0] tracker,
  input  logic [REG_W-1:0]          src,
  input  logic                      src_en,
  output logic [STAGES-1:0]         match,
  output logic                      any_match,
  output logic [IDX_W-1:0]          youngest,
  output logic                      load_use
);

  logic [MAX_REG_W-1:0] src_ext;

  assign src_ext = MAX_REG_W'(src);

  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      match[k] = src_en & tracker[k].valid & tracker[k].wb_en &
                 (tracker[k].dest == src_ext);
    end
  end

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    youngest = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (match[STAGES-1-i]) begin
        youngest = IDX_W'(STAGES - 1 - i);
      end
    end
  end

  assign any_match = |match;
  // If stage 0 matches at all it is necessarily the youngest match.
  assign load_use  = match[0] & tracker[0].mem_read;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the ID stage.
// Keeps a shadow pipeline of in-flight writebacks for STAGES stages after
// ID, raises a stall on read-after-write conflicts (all of them in
// stall-only mode, load-use only in forwarding mode), drives per-source
// forwarding selects and counts stall cycles.
//   clk, rst        : clock, synchronous active-high reset
//   id_valid        : instruction present in ID
//   src1, src2      : source registers; src2 used only when two_src=1
//   id_dest         : destination of the ID instruction
//   id_wb_en        : ID instruction writes back
//   id_mem_read     : ID instruction is a load
//   forward_en      : 1 = forwarding mode, 0 = stall-only mode
//   flush           : discard the ID instruction (insert bubble)
//   mem_stall       : pipeline freeze; tracker and counter hold
//   hazard_detected : freeze PC and IF/ID, insert bubble
//   fwd_sel1/2      : 0 = register file, k = result of tracked stage k-1
//   stall_count     : saturating count of stall cycles
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int REG_W  = 4,
  parameter  int STAGES = 3,
  parameter  int CNT_W  = 16,
  localparam int SEL_W  = sel_width(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic             forward_en,
  input  logic             flush,
  input  logic             mem_stall,
  output logic             hazard_detected,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic [CNT_W-1:0] stall_count
);

  track_entry_t [STAGES-1:0] tracker;
  track_entry_t              next_entry;

  logic [STAGES-1:0] match1, match2;
  logic              any1, any2;
  logic [SEL_W-1:0]  young1, young2;
  logic              lu1, lu2;
  logic              haz1, haz2;

  hazard_src_check #(
    .REG_W  (REG_W),
    .STAGES (STAGES),
    .IDX_W  (SEL_W)
  ) u_chk1 (
    .tracker   (tracker),
    .src       (src1),
    .src_en    (1'b1),
    .match     (match1),
    .any_match (any1),
    .youngest  (young1),
    .load_use  (lu1)
  );

  hazard_src_check #(
    .REG_W  (REG_W),
    .STAGES (STAGES),
    .IDX_W  (SEL_W)
  ) u_chk2 (
    .tracker   (tracker),
    .src       (src2),
    .src_en    (two_src),
    .match     (match2),
    .any_match (any2),
    .youngest  (young2),
    .load_use  (lu2)
  );

  always_comb begin
    haz1     = 1'b0;
    haz2     = 1'b0;
    fwd_sel1 = SEL_W'(FWD_RF);
    fwd_sel2 = SEL_W'(FWD_RF);
    if (forward_en) begin
      haz1 = lu1;
      haz2 = lu2;
      // A load still in stage 0 has no result yet, so it is not forwarded.
      if (any1 && !lu1) fwd_sel1 = young1 + SEL_W'(1);
      if (any2 && !lu2) fwd_sel2 = young2 + SEL_W'(1);
    end else begin
      haz1 = any1;
      haz2 = any2;
    end
    hazard_detected = id_valid & (haz1 | haz2);
  end

  always_comb begin
    next_entry          = '0;
    next_entry.valid    = id_valid & ~hazard_detected & ~flush;
    next_entry.wb_en    = id_wb_en;
    next_entry.mem_read = id_mem_read;
    next_entry.dest     = MAX_REG_W'(id_dest);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tracker     <= '0;
      stall_count <= '0;
    end else if (!mem_stall) begin
      for (int unsigned i = 1; i < STAGES; i++) begin
        tracker[i] <= tracker[i-1];
      end
      tracker[0] <= next_entry;
      if (hazard_detected && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int REG_W  = 4;
  localparam int STAGES = 3;
  localparam int CNT_W  = 16;
  localparam int SEL_W  = $clog2(STAGES + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, two_src = 1'b0, id_wb_en = 1'b0, id_mem_read = 1'b0;
  logic forward_en = 1'b1, flush = 1'b0, mem_stall = 1'b0;
  logic [REG_W-1:0] src1 = '0, src2 = '0, id_dest = '0;

  logic             hazard_detected, sat_hazard;
  logic [SEL_W-1:0] fwd_sel1, fwd_sel2, sat_sel1, sat_sel2;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       sat_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_W(REG_W), .STAGES(STAGES), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .forward_en(forward_en), .flush(flush),
    .mem_stall(mem_stall), .hazard_detected(hazard_detected),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_count(stall_count)
  );

  // Same stimulus, 2-bit counter to exercise saturation.
  hazard_scoreboard #(.REG_W(REG_W), .STAGES(STAGES), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .forward_en(forward_en), .flush(flush),
    .mem_stall(mem_stall), .hazard_detected(sat_hazard),
    .fwd_sel1(sat_sel1), .fwd_sel2(sat_sel2), .stall_count(sat_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: list of in-flight writebacks, index 0 = youngest.
  bit         m_v[STAGES];
  bit         m_w[STAGES];
  bit         m_m[STAGES];
  logic [3:0] m_d[STAGES];
  int         m_cnt = 0;
  bit         armed = 1'b0;
  bit         e_h;
  int         e_s1, e_s2;

  function automatic int youngest_writer(input logic [3:0] s, input bit en);
    if (!en) return -1;
    for (int k = 0; k < STAGES; k++)
      if (m_v[k] && m_w[k] && m_d[k] == s) return k;
    return -1;
  endfunction

  task automatic predict();
    int k1, k2;
    k1 = youngest_writer(src1, 1'b1);
    k2 = youngest_writer(src2, two_src);
    e_h = 1'b0; e_s1 = 0; e_s2 = 0;
    if (forward_en) begin
      if (k1 >= 0) begin
        if (k1 == 0 && m_m[0]) e_h = 1'b1; else e_s1 = k1 + 1;
      end
      if (k2 >= 0) begin
        if (k2 == 0 && m_m[0]) e_h = 1'b1; else e_s2 = k2 + 1;
      end
    end else begin
      e_h = (k1 >= 0) || (k2 >= 0);
    end
    e_h = e_h && id_valid;
  endtask

  always begin
    @(negedge clk);
    if (armed) begin
      predict();
      check("hazard", 32'(hazard_detected), 32'(e_h));
      check("fwd_sel1", 32'(fwd_sel1), 32'(e_s1));
      check("fwd_sel2", 32'(fwd_sel2), 32'(e_s2));
      check("stall_count", 32'(stall_count), 32'(m_cnt > 65535 ? 65535 : m_cnt));
      check("sat_count", 32'(sat_count), 32'(m_cnt > 3 ? 3 : m_cnt));
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        m_v[k] = 0; m_w[k] = 0; m_m[k] = 0; m_d[k] = '0;
      end
      m_cnt = 0;
      armed = 1'b1;
    end else if (armed && !mem_stall) begin
      if (e_h) m_cnt++;
      for (int k = STAGES - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_w[k] = m_w[k-1]; m_m[k] = m_m[k-1]; m_d[k] = m_d[k-1];
      end
      m_v[0] = id_valid && !e_h && !flush;
      m_w[0] = id_wb_en; m_m[0] = id_mem_read; m_d[0] = id_dest;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int s1, input int s2, input bit two,
                        input int dest, input bit wb, input bit mr);
    id_valid = v; src1 = 4'(s1); src2 = 4'(s2); two_src = two;
    id_dest = 4'(dest); id_wb_en = wb; id_mem_read = mr;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (STAGES) step();
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Reset state, reader with an empty tracker.
    set_id(1, 3, 0, 0, 0, 0, 0); #1;
    check("rst_hazard", 32'(hazard_detected), 0);
    check("rst_sel1", 32'(fwd_sel1), 0);
    check("rst_count", 32'(stall_count), 0);
    drain();

    // ADD R2, then two readers of R2 one cycle apart.
    forward_en = 1'b1;
    set_id(1, 0, 0, 0, 2, 1, 0); step();
    set_id(1, 2, 0, 0, 7, 1, 0); #1;
    check("add_fwd_hazard", 32'(hazard_detected), 0);
    check("add_fwd_sel1_exe", 32'(fwd_sel1), 1);
    step();
    set_id(1, 2, 0, 0, 8, 0, 0); #1;
    check("add_fwd_sel1_mem", 32'(fwd_sel1), 2);
    step(); drain();

    // LDR R5 then a src2 reader: one load-use stall, then MEM forward.
    set_id(1, 0, 0, 0, 5, 1, 1); step();
    set_id(1, 1, 5, 1, 9, 1, 0); #1;
    check("lu_hazard", 32'(hazard_detected), 1);
    step(); #1;
    check("lu_hazard_clear", 32'(hazard_detected), 0);
    check("lu_sel2", 32'(fwd_sel2), 2);
    check("lu_count", 32'(stall_count), 1);
    step(); drain();

    // Stall-only mode: held for STAGES cycles.
    forward_en = 1'b0;
    set_id(1, 0, 0, 0, 5, 1, 1); step();
    set_id(1, 1, 5, 1, 9, 1, 0);
    for (int c = 0; c < STAGES; c++) begin
      #1; check("so_hazard_held", 32'(hazard_detected), 1);
      step();
    end
    #1;
    check("so_hazard_clear", 32'(hazard_detected), 0);
    check("so_sel2", 32'(fwd_sel2), 0);
    check("so_count", 32'(stall_count), 4);
    step(); drain();

    // two_src=0 ignores src2; flushed writer leaves no dependency.
    forward_en = 1'b1;
    set_id(1, 0, 0, 0, 6, 1, 1); step();
    set_id(1, 1, 6, 0, 0, 0, 0); #1;
    check("one_src_hazard", 32'(hazard_detected), 0);
    check("one_src_sel2", 32'(fwd_sel2), 0);
    step(); drain();
    flush = 1'b1;
    set_id(1, 0, 0, 0, 10, 1, 0); step();
    flush = 1'b0;
    set_id(1, 10, 0, 0, 0, 0, 0); #1;
    check("flush_hazard", 32'(hazard_detected), 0);
    check("flush_sel1", 32'(fwd_sel1), 0);
    step(); drain();

    // Freeze during a load-use stall.
    set_id(1, 0, 0, 0, 11, 1, 1); step();
    set_id(1, 11, 0, 0, 0, 0, 0);
    mem_stall = 1'b1;
    repeat (4) begin
      #1;
      check("frz_hazard", 32'(hazard_detected), 1);
      check("frz_count", 32'(stall_count), 4);
      step();
    end
    mem_stall = 1'b0; #1;
    check("rel_hazard", 32'(hazard_detected), 1);
    step(); #1;
    check("rel_count", 32'(stall_count), 5);
    check("rel_hazard_clear", 32'(hazard_detected), 0);
    check("rel_sel1", 32'(fwd_sel1), 2);
    check("sat_count_lit", 32'(sat_count), 3);
    step(); drain();

    // Reset under freeze still clears in-flight writers.
    set_id(1, 0, 0, 0, 12, 1, 0); step();
    rst = 1'b1; mem_stall = 1'b1; step();
    rst = 1'b0; mem_stall = 1'b0;
    set_id(1, 12, 0, 0, 0, 0, 0); #1;
    check("mid_rst_hazard", 32'(hazard_detected), 0);
    check("mid_rst_sel1", 32'(fwd_sel1), 0);
    check("mid_rst_count", 32'(stall_count), 0);
    step();

    // Mixed traffic over a small register set, checked by the model.
    for (int c = 0; c < 80; c++) begin
      set_id(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             ($urandom_range(0, 2) == 0));
      forward_en = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 7) == 0);
      mem_stall  = ($urandom_range(0, 5) == 0);
      step();
    end
    flush = 1'b0; mem_stall = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
